pipeline_hazard_controller: RTL
===============================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning the number of advancing cycles for a halt instruction to travel from ID to WB.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL have ports rs_ID and rt_ID, input, 2 each, source register fields of the instruction in ID.
REQ-005 SHALL have ports use_rs_ID and use_rt_ID, input, 1 each, meaning the ID instruction actually reads rs or rt.
REQ-006 SHALL have ports write_reg_addr_EX (input, 2), RegWrite_EX (input, 1) and d_readM_EX (input, 1), the destination, write enable and load flag of the instruction in EX.
REQ-007 SHALL have port mispredict_EX, input, 1, meaning a branch resolved in EX disagrees with branch_predicted_pc_EX.
REQ-008 SHALL have port jump_redirect_ID, input, 1, meaning a jump decoded in ID redirects the PC.
REQ-009 SHALL have ports is_halted_ID (input, 1) and i_ready (input, 1), halt decode and instruction-memory data valid.
REQ-010 SHALL have ports d_access_MEM (input, 1) and d_ready (input, 1), where d_access_MEM = d_readM_MEM | d_writeM_MEM, and d_ready is data-memory completion.
REQ-011 SHALL have output pc_write, 1, enabling the PC update.
REQ-012 SHALL have outputs stall_IF_ID, stall_ID_EX and stall_EX_MEM, 1 each, driving the stall (hold) inputs of the three pipeline registers.
REQ-013 SHALL have outputs flush_IF_ID, flush_ID_EX and flush_EX_MEM, 1 each, driving the flush (clear-to-bubble) inputs of the three pipeline registers.
REQ-014 SHALL have output halted, 1, asserted in HALTED state.
REQ-015 SHALL have outputs stall_count and flush_count, 16 each, saturating performance counters.

Function
REQ-016 SHALL implement FSM states RUN, DRAIN and HALTED, with a 2-bit drain counter.
REQ-017 SHALL define mem_wait = d_access_MEM & ~d_ready.
REQ-018 SHALL define load_use = d_readM_EX & RegWrite_EX & ((use_rs_ID & rs_ID==write_reg_addr_EX) | (use_rt_ID & rt_ID==write_reg_addr_EX)).
REQ-019 SHALL, in RUN, apply priority mem_wait > mispredict_EX > load_use > jump_redirect_ID > ~i_ready; outputs not named in the selected case are 0 except pc_write, which is 1.
REQ-020 SHALL, on mem_wait, drive pc_write=0 and all three stalls=1, with no flush asserted.
REQ-021 SHALL, on mispredict_EX, drive flush_IF_ID=1, flush_ID_EX=1 and pc_write=1.
REQ-022 SHALL, on load_use, drive pc_write=0, stall_IF_ID=1 and flush_ID_EX=1, giving exactly one bubble per load-use pair.
REQ-023 SHALL, on jump_redirect_ID, drive flush_IF_ID=1 and pc_write=1.
REQ-024 SHALL, on ~i_ready alone, drive pc_write=0 and flush_IF_ID=1.
REQ-025 SHALL move RUN->DRAIN when is_halted_ID=1 and no higher-priority case is active, loading the counter with DRAIN_CYCLES-1.
REQ-026 SHALL, in DRAIN, drive pc_write=0 and flush_IF_ID=1.
REQ-027 SHALL, in DRAIN, decrement the counter only on cycles without mem_wait; mem_wait behaves as in REQ-020.
REQ-028 SHALL move DRAIN->HALTED when the counter is 0 on a non-mem_wait cycle.
REQ-029 SHALL, on mispredict_EX while in DRAIN, treat the halt as wrong-path: apply REQ-021 and return to RUN.
REQ-030 SHALL, in HALTED, drive pc_write=0, all stalls=1, all flushes=0 and halted=1, holding until reset.
REQ-031 SHALL never assert a stall and a flush on the same register in one cycle; when both are requested, the flush wins, except under mem_wait.
REQ-032 SHALL increment stall_count on each cycle with pc_write=0 outside HALTED, saturating at 16'hFFFF.
REQ-033 SHALL increment flush_count on each cycle with any flush asserted outside reset, saturating at 16'hFFFF.
REQ-034 SHALL derive all pipeline outputs combinationally from the current state and inputs (zero latency); only the FSM, drain counter and perf counters are registered.

Reset
REQ-035 SHALL, while reset=1, force state=RUN, counter=0, stall_count=0 and flush_count=0.
REQ-036 SHALL, while reset=1, force pc_write=0, all stalls=0, all three flushes=1 and halted=0.
REQ-037 SHALL let reset mid-DRAIN or in HALTED return to RUN on the next edge.

Verification
REQ-038 SHALL cover load-use: d_readM_EX=1, RegWrite_EX=1, write_reg_addr_EX=2, rs_ID=2, use_rs_ID=1 -> pc_write=0, stall_IF_ID=1, flush_ID_EX=1; stall_count increments by 1.
REQ-039 SHALL cover mispredict plus load_use in the same cycle -> flush_IF_ID=1, flush_ID_EX=1, pc_write=1, stall_IF_ID=0.
REQ-040 SHALL cover mem_wait for 4 cycles with mispredict_EX=1 -> all stalls=1, no flush for 4 cycles; on cycle 5 with d_ready=1 -> mispredict flush applied.
REQ-041 SHALL cover halt: is_halted_ID=1 with no hazards -> exactly 3 DRAIN cycles with flush_IF_ID=1, then halted=1 and all stalls=1.
REQ-042 SHALL cover a halt drain interrupted by mispredict_EX on drain cycle 2 -> return to RUN, halted remains 0.
REQ-043 SHALL cover counter saturation: preload to 16'hFFFE, then 3 stall cycles -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a 5-stage pipeline: stall/flush arbitration, halt drain
// sequencing and saturating stall/flush performance counters.
module pipeline_hazard_controller #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rs_ID,
    input  logic [1:0]  rt_ID,
    input  logic        use_rs_ID,
    input  logic        use_rt_ID,
    input  logic [1:0]  write_reg_addr_EX,
    input  logic        RegWrite_EX,
    input  logic        d_readM_EX,
    input  logic        mispredict_EX,
    input  logic        jump_redirect_ID,
    input  logic        is_halted_ID,
    input  logic        i_ready,
    input  logic        d_access_MEM,
    input  logic        d_ready,
    output logic        pc_write,
    output logic        stall_IF_ID,
    output logic        stall_ID_EX,
    output logic        stall_EX_MEM,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic        flush_EX_MEM,
    output logic        halted,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    // state  | meaning
    // RUN    | normal issue, hazards arbitrated by priority
    // DRAIN  | halt travelling ID->WB, fetch squashed
    // HALTED | pipeline frozen until reset
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic mem_wait, load_use;
    logic s_if, s_id, s_ex, f_if, f_id, f_ex;

    assign mem_wait = d_access_MEM & ~d_ready;
    assign load_use = d_readM_EX & RegWrite_EX &
                      ((use_rs_ID & (rs_ID == write_reg_addr_EX)) |
                       (use_rt_ID & (rt_ID == write_reg_addr_EX)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_write = 1'b1;
        s_if     = 1'b0;
        s_id     = 1'b0;
        s_ex     = 1'b0;
        f_if     = 1'b0;
        f_id     = 1'b0;
        f_ex     = 1'b0;
        halted   = 1'b0;
        if (reset) begin
            pc_write = 1'b0;
            f_if     = 1'b1;
            f_id     = 1'b1;
            f_ex     = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        pc_write = 1'b0;
                        s_if = 1'b1; s_id = 1'b1; s_ex = 1'b1;
                    end else if (mispredict_EX) begin
                        f_if = 1'b1; f_id = 1'b1;
                    end else if (load_use) begin
                        pc_write = 1'b0;
                        s_if = 1'b1; f_id = 1'b1;
                    end else if (jump_redirect_ID) begin
                        f_if = 1'b1;
                    end else if (!i_ready) begin
                        pc_write = 1'b0;
                        f_if = 1'b1;
                    end else if (is_halted_ID) begin
                        state_d = DRAIN;
                        cnt_d   = 2'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (mem_wait) begin
                        pc_write = 1'b0;
                        s_if = 1'b1; s_id = 1'b1; s_ex = 1'b1;
                    end else if (mispredict_EX) begin
                        // halt was fetched down the wrong path
                        f_if    = 1'b1; f_id = 1'b1;
                        state_d = RUN;
                    end else begin
                        pc_write = 1'b0;
                        f_if     = 1'b1;
                        if (cnt_q == 2'd0) state_d = HALTED;
                        else               cnt_d   = cnt_q - 2'd1;
                    end
                end
                HALTED: begin
                    pc_write = 1'b0;
                    s_if = 1'b1; s_id = 1'b1; s_ex = 1'b1;
                    halted = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // a flush on a register always overrides a hold on the same register
    assign stall_IF_ID  = s_if & ~f_if;
    assign stall_ID_EX  = s_id & ~f_id;
    assign stall_EX_MEM = s_ex & ~f_ex;
    assign flush_IF_ID  = f_if;
    assign flush_ID_EX  = f_id;
    assign flush_EX_MEM = f_ex;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!pc_write && state_q != HALTED && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
        if ((f_if | f_id | f_ex) && flush_count_q != 16'hFFFF)
            flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            cnt_q         <= 2'd0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
